// File: rtl/misr_pkg.sv
// misr_pkg: shared definitions for the MISR signature compactor.
//   - default parameter values (width, feedback mask, seed, counter width)
//   - FSM state encoding used by misr_compactor
package misr_pkg;

    localparam int unsigned MISR_WIDTH    = 3;
    localparam logic [2:0]  MISR_TAP_MASK = 3'b010;
    localparam int unsigned MISR_SEED     = 0;
    localparam int unsigned MISR_CNT_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } misr_state_e;

endpackage

// File: rtl/misr_step.sv
// misr_step: one combinational MISR update.
//   i_sig  - current signature
//   i_data - response word folded in this step
//   o_next - next signature
// Bit 0 always takes the MSB feedback; higher bits take it only where
// TAP_MASK has a 1.
module misr_step
    import misr_pkg::*;
#(
    parameter int unsigned          WIDTH    = MISR_WIDTH,
    parameter logic [WIDTH-1:0]     TAP_MASK = WIDTH'(MISR_TAP_MASK)
) (
    input  logic [WIDTH-1:0] i_sig,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_next
);

    always_comb begin
        o_next    = '0;
        o_next[0] = i_sig[WIDTH-1] ^ i_data[0];
        for (int i = 1; i < int'(WIDTH); i++) begin
            o_next[i] = i_sig[i-1] ^ i_data[i] ^ (TAP_MASK[i] & i_sig[WIDTH-1]);
        end
    end

endmodule

// File: rtl/misr_compactor.sv
// misr_compactor: compacts a stream of response words into a MISR signature
// and compares it with a golden value at the end of the session.
//   clk, rst_n         - clock, synchronous active-low reset
//   start              - single-cycle session request (accepted in IDLE/DONE)
//   num_patterns       - number of responses to compact (latched on start)
//   golden             - expected signature (latched on start)
//   resp_valid/data    - response word, folded in only while running
//   busy               - session in progress (RUN or CHECK)
//   done, pass         - session finished / signature matched golden
//   signature, count   - current signature and accepted-response count
module misr_compactor
    import misr_pkg::*;
#(
    parameter int unsigned      WIDTH    = MISR_WIDTH,
    parameter logic [WIDTH-1:0] TAP_MASK = WIDTH'(MISR_TAP_MASK),
    parameter logic [WIDTH-1:0] SEED     = WIDTH'(MISR_SEED),
    parameter int unsigned      CNT_W    = MISR_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic [WIDTH-1:0] golden,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] count
);

    misr_state_e      r_state;
    misr_state_e      w_state_next;
    logic [WIDTH-1:0] r_sig;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_num;
    logic [WIDTH-1:0] r_golden;
    logic             r_pass;

    logic [WIDTH-1:0] w_sig_next;
    logic             w_load;
    logic             w_accept;
    logic             w_last;

    misr_step #(
        .WIDTH    (WIDTH),
        .TAP_MASK (TAP_MASK)
    ) u_step (
        .i_sig  (r_sig),
        .i_data (resp_data),
        .o_next (w_sig_next)
    );

    assign w_load   = start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_accept = resp_valid && (r_state == ST_RUN);
    // RUN is only entered with r_num >= 1, so r_num-1 never underflows here;
    // count therefore tops out at r_num and cannot wrap.
    assign w_last   = w_accept && (r_count == r_num - CNT_W'(1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) w_state_next = (num_patterns == '0) ? ST_CHECK : ST_RUN;
            end
            ST_RUN: begin
                if (w_last) w_state_next = ST_CHECK;
            end
            ST_CHECK: w_state_next = ST_DONE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_sig    <= SEED;
            r_count  <= '0;
            r_num    <= '0;
            r_golden <= '0;
            r_pass   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_sig    <= SEED;
                r_count  <= '0;
                r_num    <= num_patterns;
                r_golden <= golden;
                r_pass   <= 1'b0;
            end
            if (w_accept) begin
                r_sig   <= w_sig_next;
                r_count <= r_count + CNT_W'(1);
            end
            if (r_state == ST_CHECK) begin
                r_pass <= (r_sig == r_golden);
            end
        end
    end

    assign busy      = (r_state == ST_RUN) || (r_state == ST_CHECK);
    assign done      = (r_state == ST_DONE);
    assign pass      = r_pass;
    assign signature = r_sig;
    assign count     = r_count;

endmodule
